// File: rtl/ram_write_arbiter_pkg.sv
// Shared definitions for the write arbiter that feeds the replicated 8R1W memory.
// Holds the default geometry and the round-robin pointer advance rule.
package ram_write_arbiter_pkg;

  localparam int unsigned BLOCLSIZE_DEF  = 12;
  localparam int unsigned NUM_CH_DEF     = 4;
  localparam int unsigned FIFO_DEPTH_DEF = 2;
  localparam int unsigned DATA_W_DEF     = 32;

  // Next round-robin start position: the channel after the one just granted.
  function automatic int unsigned rr_next(input int unsigned winner,
                                          input int unsigned num_ch);
    return (winner + 1) % num_ch;
  endfunction

endpackage

// File: rtl/ram_write_arbiter_if.sv
// Request/write bundle for ram_write_arbiter.
//  req_valid/req_ready : per-channel handshake
//  req_addr/req_data   : per-channel packed address/data slices
//  w_enb/w_addr/w_din  : registered memory write port
//  grant_ch            : channel behind the current write
//  idle                : nothing buffered and no write in flight
// slave = arbiter side, master = request source / memory observer side.
interface ram_write_arbiter_if
  import ram_write_arbiter_pkg::*;
#(
  parameter int unsigned BLOCLSIZE = BLOCLSIZE_DEF,
  parameter int unsigned NUM_CH    = NUM_CH_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF
);
  localparam int unsigned AW   = BLOCLSIZE + 1;
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_ready;
  logic [NUM_CH*AW-1:0]     req_addr;
  logic [NUM_CH*DATA_W-1:0] req_data;
  logic                     w_enb;
  logic [AW-1:0]            w_addr;
  logic [DATA_W-1:0]        w_din;
  logic [CH_W-1:0]          grant_ch;
  logic                     idle;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, w_enb, w_addr, w_din, grant_ch, idle
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, w_enb, w_addr, w_din, grant_ch, idle
  );

endinterface

// File: rtl/ram_write_arbiter_wr_req_fifo.sv
// wr_req_fifo: per-channel synchronous FIFO holding {addr,data} write requests.
//  clk, rst  : clock, synchronous active-high flush
//  push_i    : write din_i (caller guarantees not full)
//  pop_i     : drop head (caller guarantees not empty)
//  dout_o    : head entry, valid while empty_o=0
//  full_o, empty_o, count_o : occupancy
module wr_req_fifo #(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned WIDTH = 45,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (pop_i) rd_q <= rd_q + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

  assign dout_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push_i && full_o));
      assert (!(pop_i && empty_o));
    end
  end

endmodule

// File: rtl/ram_write_arbiter.sv
// ram_write_arbiter: merges NUM_CH buffered write-request channels into the single
// registered write port of the replicated memory, serving non-empty channels
// round-robin at one write per clock.
//  clk  : clock
//  rst  : synchronous active-high reset; flushes all FIFOs
//  bus  : slave side of ram_write_arbiter_if (request handshakes + write port)
module ram_write_arbiter
  import ram_write_arbiter_pkg::*;
#(
  parameter int unsigned BLOCLSIZE  = BLOCLSIZE_DEF,
  parameter int unsigned NUM_CH     = NUM_CH_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF
) (
  input logic               clk,
  input logic               rst,
  ram_write_arbiter_if.slave bus
);

  localparam int unsigned AW    = BLOCLSIZE + 1;
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_CH-1:0] push, pop, full, empty;
  logic [AW-1:0]     head_addr [NUM_CH];
  logic [DATA_W-1:0] head_data [NUM_CH];
  logic [CNT_W-1:0]  count     [NUM_CH];

  logic [CH_W-1:0]   rr_ptr_q;
  logic [CH_W-1:0]   winner, cand;
  logic              found;
  logic              pending;

  logic              w_enb_q;
  logic [AW-1:0]     w_addr_q;
  logic [DATA_W-1:0] w_din_q;
  logic [CH_W-1:0]   grant_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Ready depends only on registered occupancy, so a full FIFO refuses even
    // when it is being popped on the same edge.
    assign bus.req_ready[i] = ~full[i] & ~rst;
    assign push[i]          = bus.req_valid[i] & bus.req_ready[i];
    assign pop[i]           = found & (winner == CH_W'(i));

    wr_req_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (AW + DATA_W)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push[i]),
      .pop_i   (pop[i]),
      .din_i   ({bus.req_addr[i*AW +: AW], bus.req_data[i*DATA_W +: DATA_W]}),
      .dout_o  ({head_addr[i], head_data[i]}),
      .full_o  (full[i]),
      .empty_o (empty[i]),
      .count_o (count[i])
    );
  end

  // Scan from rr_ptr upward, wrapping modulo NUM_CH; first non-empty FIFO wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      cand = CH_W'((32'(rr_ptr_q) + k) % NUM_CH);
      if (!found && !empty[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    pending = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pending = pending | (|count[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      w_enb_q  <= 1'b0;
      w_addr_q <= '0;
      w_din_q  <= '0;
      grant_q  <= '0;
    end else if (found) begin
      w_enb_q  <= 1'b1;
      w_addr_q <= head_addr[winner];
      w_din_q  <= head_data[winner];
      grant_q  <= winner;
      rr_ptr_q <= CH_W'(rr_next(32'(winner), NUM_CH));
    end else begin
      w_enb_q  <= 1'b0;
    end
  end

  assign bus.w_enb    = w_enb_q;
  assign bus.w_addr   = w_addr_q;
  assign bus.w_din    = w_din_q;
  assign bus.grant_ch = grant_q;
  assign bus.idle     = ~pending & ~w_enb_q;

endmodule

// File: tb/tb_ram_write_arbiter.sv
module tb_ram_write_arbiter;
  localparam int unsigned BLOCLSIZE  = 12;
  localparam int unsigned NUM_CH     = 4;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned AW         = BLOCLSIZE + 1;

  typedef struct packed {
    logic [AW-1:0]     a;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_write_arbiter_if #(.BLOCLSIZE(BLOCLSIZE), .NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  ram_write_arbiter #(
    .BLOCLSIZE  (BLOCLSIZE),
    .NUM_CH     (NUM_CH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (DATA_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: per-channel request queues plus round-robin start position.
  ent_t              mq [NUM_CH][$];
  int unsigned       rr;
  logic              e_enb;
  logic [AW-1:0]     e_addr;
  logic [DATA_W-1:0] e_din;
  logic [1:0]        e_grant;

  logic [NUM_CH-1:0] valid_v;
  logic [NUM_CH-1:0] last_acc;
  logic [AW-1:0]     addr_v [NUM_CH];
  logic [DATA_W-1:0] data_v [NUM_CH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check ready, advance model, check registered outputs.
  task automatic tick();
    logic [NUM_CH-1:0] rdy;
    logic [NUM_CH-1:0] acc;
    int                w;
    int                c;
    logic              model_idle;
    ent_t              e;
    bus.req_valid = valid_v;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.req_addr[i*AW +: AW]         = addr_v[i];
      bus.req_data[i*DATA_W +: DATA_W] = data_v[i];
    end
    #1;
    for (int i = 0; i < NUM_CH; i++)
      rdy[i] = !rst && (mq[i].size() < FIFO_DEPTH);
    chk("req_ready", 64'(bus.req_ready), 64'(rdy));
    acc = valid_v & rdy;
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) mq[i].delete();
      rr = 0; e_enb = 1'b0; e_addr = '0; e_din = '0; e_grant = '0;
    end else begin
      w = -1;
      for (int k = 0; k < NUM_CH; k++) begin
        c = (int'(rr) + k) % NUM_CH;
        if (w < 0 && mq[c].size() > 0) w = c;
      end
      if (w >= 0) begin
        e = mq[w].pop_front();
        e_enb = 1'b1; e_addr = e.a; e_din = e.d; e_grant = 2'(w);
        rr = (w + 1) % NUM_CH;
      end else begin
        e_enb = 1'b0;
      end
      for (int i = 0; i < NUM_CH; i++)
        if (acc[i]) mq[i].push_back('{a: addr_v[i], d: data_v[i]});
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    model_idle = !e_enb;
    for (int i = 0; i < NUM_CH; i++) if (mq[i].size() != 0) model_idle = 1'b0;
    chk("w_enb",    64'(bus.w_enb),    64'(e_enb));
    chk("w_addr",   64'(bus.w_addr),   64'(e_addr));
    chk("w_din",    64'(bus.w_din),    64'(e_din));
    chk("grant_ch", 64'(bus.grant_ch), 64'(e_grant));
    chk("idle",     64'(bus.idle),     64'(model_idle));
    @(negedge clk);
  endtask

  // Handshake rule: a channel presents new content only after its request was taken.
  task automatic refresh(input logic rand_data);
    for (int i = 0; i < NUM_CH; i++) begin
      if (last_acc[i]) begin
        addr_v[i] = AW'($urandom);
        data_v[i] = rand_data ? $urandom : DATA_W'(i);
      end
    end
  endtask

  initial begin
    int n;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    rr = 0; e_enb = 1'b0; e_addr = '0; e_din = '0; e_grant = '0;
    last_acc = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      addr_v[i] = AW'($urandom);
      data_v[i] = $urandom;
    end

    // Reset held 3 cycles with all channels requesting.
    rst = 1'b1; valid_v = 4'hF;
    repeat (3) tick();
    rst = 1'b0; valid_v = '0;
    tick();
    chk("idle_after_rst", 64'(bus.idle), 64'd1);

    // Single write on ch2.
    valid_v = 4'b0100; addr_v[2] = 13'h0A5; data_v[2] = 32'hDEADBEEF;
    tick();
    valid_v = '0;
    repeat (3) tick();

    // Round-robin with all channels saturated, data = channel id.
    for (int i = 0; i < NUM_CH; i++) data_v[i] = DATA_W'(i);
    valid_v = 4'hF;
    repeat (16) begin tick(); refresh(1'b0); end
    valid_v = '0;
    repeat (10) tick();

    // Backpressure: ch1 streams while ch0 and ch3 compete.
    refresh(1'b1);
    valid_v = 4'b1011;
    repeat (24) begin tick(); refresh(1'b1); end
    valid_v = '0;
    repeat (10) tick();

    // Single-channel throughput: ch3, addr 0..15.
    n = 0;
    valid_v = 4'b1000;
    for (int c = 0; c < 40 && n < 16; c++) begin
      addr_v[3] = AW'(n);
      data_v[3] = $urandom;
      tick();
      if (last_acc[3]) n++;
    end
    chk("t5_accepted", 64'(n), 64'd16);
    valid_v = '0;
    repeat (4) tick();

    // Reset mid-burst with five entries buffered.
    for (int i = 0; i < NUM_CH; i++) begin
      addr_v[i] = AW'($urandom); data_v[i] = $urandom;
    end
    valid_v = 4'b0111;
    tick(); refresh(1'b1);
    tick(); refresh(1'b1);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0; valid_v = '0;
    repeat (6) tick();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 100; c++) begin
      valid_v = NUM_CH'($urandom);
      rst     = ($urandom_range(0, 19) == 0);
      tick();
      refresh(1'b1);
    end
    rst = 1'b0; valid_v = '0;
    repeat (12) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
